qspi_fetch_arbiter: RTL and testbench

// - Shares the single quad-SPI flash (W25Q128, Fast Read Quad Output 6Bh) between two requesters: video line fetch (req 0) and audio sample fetch (req 1).
// - Arbitrates, sequences CMD/ADDR/DUMMY/READ, streams bytes back to the granted requester.
// - Sits between the VGA player datapath and the uio pins; replaces the inline SPI sequencing in the player top.

---
 rtl/qspi_pkg.sv | 11 +
 rtl/qspi_shift_unit.sv | 38 +++
 rtl/qspi_fetch_arbiter.sv | 129 ++++++++++++
 tb/tb_qspi_fetch_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: flash read command, address width and FSM state encoding shared by the fetch arbiter.
package qspi_pkg;
   localparam logic [7:0] CMD_FAST_READ_QUAD = 8'h6B;
   localparam int         ADDR_BITS          = 24;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CMD   = 3'd1;
   localparam logic [2:0] ADDR  = 3'd2;
   localparam logic [2:0] DUMMY = 3'd3;
   localparam logic [2:0] READ  = 3'd4;
   localparam logic [2:0] GAP   = 3'd5;
endpackage

// File: rtl/qspi_shift_unit.sv
// qspi_shift_unit: serialises command and address on IO0, assembles returned nibbles into bytes.
module qspi_shift_unit
   import qspi_pkg::*;
#(
   parameter int PH_W = 8
) (
   input  logic                 px_clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 shift,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [3:0]           io_in,
   output logic                 bit_out,
   output logic [7:0]           byte_data,
   output logic                 byte_strobe,
   output logic [PH_W-1:0]      phase
);
   logic [ADDR_BITS+7:0] sreg;
   logic [3:0]           io_q, hi;
   assign bit_out = sreg[ADDR_BITS+7];
   // phase 0 only fills io_q; odd phases take the high nibble, even phases complete a byte
   assign byte_strobe = rd_en && !phase[0] && |phase;
   always_ff @(posedge px_clk)
      if (reset) begin
         sreg      <= '0;
         io_q      <= '0;
         hi        <= '0;
         phase     <= '0;
         byte_data <= '0;
      end else begin
         sreg  <= load ? {CMD_FAST_READ_QUAD, addr} : shift ? sreg << 1 : sreg;
         io_q  <= io_in;
         phase <= rd_en ? phase + PH_W'(1) : '0;
         if (rd_en && phase[0]) hi <= io_q;
         if (byte_strobe) byte_data <= {hi, io_q};
      end
endmodule

// File: rtl/qspi_fetch_arbiter.sv
// qspi_fetch_arbiter: shares one quad-SPI flash between video (req 0) and audio (req 1) fetchers.
// Define QSPI_RR_ARB_EN for round-robin arbitration; default is fixed priority req[0] > req[1].
module qspi_fetch_arbiter
   import qspi_pkg::*;
#(
   parameter int LEN_W       = 7,
   parameter int DUMMY_CYC   = 8,
   parameter int CS_HIGH_CYC = 2
) (
   input  logic                 px_clk,
   input  logic                 reset,
   input  logic [1:0]           req,
   input  logic [ADDR_BITS-1:0] req0_addr,
   input  logic [LEN_W-1:0]     req0_len,
   input  logic [ADDR_BITS-1:0] req1_addr,
   input  logic [LEN_W-1:0]     req1_len,
   output logic [1:0]           gnt,
   output logic [7:0]           rd_data,
   output logic [1:0]           rd_valid,
   output logic [1:0]           done,
   output logic                 busy,
   output logic                 spi_cs_n,
   output logic                 spi_clk_en,
   output logic [3:0]           spi_io_out,
   output logic [3:0]           spi_io_oe,
   input  logic [3:0]           spi_io_in
);
   localparam logic [7:0] CMD_LAST   = 8'd7;
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'(CS_HIGH_CYC - 1);
   logic [2:0]           state;
   logic [7:0]           cnt;
   logic [LEN_W-1:0]     len_q, win_len;
   logic [ADDR_BITS-1:0] win_addr;
   logic [LEN_W:0]       phase;
   logic                 win, nz, zlen, load, shift, bit_out, byte_strobe, rd_last;
`ifdef QSPI_RR_ARB_EN
   logic last;
   // the requester granted most recently loses a tie
   assign win = &req ? ~last : req[1];
`else
   assign win = ~req[0];
`endif
   assign win_addr   = win ? req1_addr : req0_addr;
   assign win_len    = win ? req1_len : req0_len;
   assign nz         = |win_len;
   assign load       = state == IDLE && |req && nz;
   assign shift      = state == CMD || state == ADDR;
   assign rd_last    = byte_strobe && phase == {len_q, 1'b0};
   assign spi_io_out = {3'b000, bit_out};
   qspi_shift_unit #(.PH_W(LEN_W + 1)) u_shift (
      .px_clk      (px_clk),
      .reset       (reset),
      .load        (load),
      .shift       (shift),
      .rd_en       (state == READ),
      .addr        (win_addr),
      .io_in       (spi_io_in),
      .bit_out     (bit_out),
      .byte_data   (rd_data),
      .byte_strobe (byte_strobe),
      .phase       (phase)
   );
   always_ff @(posedge px_clk)
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         len_q      <= '0;
         zlen       <= 1'b0;
         gnt        <= '0;
         busy       <= 1'b0;
         spi_cs_n   <= 1'b1;
         spi_clk_en <= 1'b0;
         spi_io_oe  <= '0;
         rd_valid   <= '0;
         done       <= '0;
`ifdef QSPI_RR_ARB_EN
         last       <= 1'b1;
`endif
      end else begin
         rd_valid <= byte_strobe ? gnt : 2'b00;
         done     <= rd_last ? gnt : 2'b00;
         cnt      <= cnt + 8'd1;
`ifdef QSPI_RR_ARB_EN
         if (state == IDLE && |req) last <= win;
`endif
         case (state)
            IDLE: if (|req) begin
               gnt        <= win ? 2'b10 : 2'b01;
               busy       <= 1'b1;
               len_q      <= win_len;
               cnt        <= '0;
               zlen       <= !nz;
               spi_cs_n   <= !nz;
               spi_clk_en <= nz;
               spi_io_oe  <= {3'b000, nz};
               state      <= nz ? CMD : GAP;
            end
            CMD: if (cnt == CMD_LAST) begin
               cnt   <= '0;
               state <= ADDR;
            end
            ADDR: if (cnt == ADDR_LAST) begin
               cnt       <= '0;
               spi_io_oe <= '0;
               state     <= DUMMY;
            end
            DUMMY: if (cnt == DUMMY_LAST) state <= READ;
            READ: if (rd_last) begin
               cnt   <= '0;
               state <= GAP;
            end
            GAP: begin
               // a zero-length burst reports done here, one cycle after its grant
               done       <= zlen ? gnt : 2'b00;
               zlen       <= 1'b0;
               gnt        <= '0;
               spi_cs_n   <= 1'b1;
               spi_clk_en <= 1'b0;
               if (cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_qspi_fetch_arbiter.sv
// tb_qspi_fetch_arbiter: directed vectors against a behavioural W25Q128 quad-output read model.
module tb_qspi_fetch_arbiter;
   logic        px_clk = 1'b0, reset = 1'b1;
   logic [1:0]  req = '0;
   logic [23:0] req0_addr = '0, req1_addr = '0;
   logic [6:0]  req0_len = '0, req1_len = '0;
   logic [1:0]  gnt, rd_valid, done;
   logic [7:0]  rd_data;
   logic        busy, spi_cs_n, spi_clk_en;
   logic [3:0]  spi_io_out, spi_io_oe;
   logic [3:0]  spi_io_in = '0;
   wire         spi_clk = ~px_clk & spi_clk_en;
   qspi_fetch_arbiter dut (
      .px_clk(px_clk), .reset(reset), .req(req),
      .req0_addr(req0_addr), .req0_len(req0_len), .req1_addr(req1_addr), .req1_len(req1_len),
      .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
      .spi_cs_n(spi_cs_n), .spi_clk_en(spi_clk_en), .spi_io_out(spi_io_out),
      .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
   );
   always #5 px_clk = ~px_clk;
   // flash model: 8 cmd + 24 addr bits on IO0, 8 dummy clocks, then nibbles after each falling spi_clk
   logic [31:0] cap = '0;
   logic [7:0]  mem [256];
   logic [7:0]  fa, fb;
   int          fclk = 0, nidx = 0;
   always @(posedge spi_clk) begin
      if (fclk < 32) cap = {cap[30:0], spi_io_out[0]};
      fclk++;
   end
   always @(negedge spi_clk) if (fclk >= 40) begin
      #1;
      fa = cap[7:0] + 8'(nidx / 2);
      fb = mem[fa];
      spi_io_in = nidx[0] ? fb[3:0] : fb[7:4];
      nidx++;
   end
   always @(negedge px_clk) if (spi_cs_n) begin
      fclk = 0;
      nidx = 0;
   end
   typedef struct {
      logic [1:0]  req;
      logic [23:0] a0;
      logic [6:0]  l0;
      logic [23:0] a1;
      logic [6:0]  l1;
      logic [1:0]  eg;
      logic [23:0] ea;
      int          el;
   } vec_t;
   vec_t vt[5];
   int tests = 0, fails = 0, gap_n = 0, seen = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic step;
      @(posedge px_clk);
      #1;
   endtask
   task automatic wait_idle;
      for (int n = 0; n < 20 && busy; n++) step();
      check("idle", 32'(busy), 0);
   endtask
   task automatic wait_grant(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (gnt == 2'b00 && n < 20);
   endtask
   // entered just after the request-sampling edge; leaves just after the edge following done
   task automatic burst(input string tag, input logic [1:0] eg, input logic [23:0] ea, input int el);
      int first_n = -1, nb = 0, bad = 0, done_n = -1;
      check({tag, " gnt"}, 32'(gnt), 32'(eg));
      check({tag, " cs_n/busy"}, {spi_cs_n, busy}, 2'b01);
      check({tag, " oe cmd"}, 32'(spi_io_oe), 1);
      for (int n = 1; n <= 2 * el + 48 && done_n < 0; n++) begin
         step();
         if (n == 32) check({tag, " oe dummy"}, 32'(spi_io_oe), 0);
         if (rd_valid != 2'b00) begin
            if (first_n < 0) first_n = n;
            if (rd_valid !== eg || rd_data !== mem[8'(ea[7:0] + 8'(nb))]) bad++;
            nb++;
         end
         if (done != 2'b00) begin
            done_n = n;
            if (done !== eg || rd_valid !== eg) bad++;
         end
      end
      check({tag, " first latency"}, first_n, 43);
      check({tag, " byte count"}, nb, el);
      check({tag, " bad bytes"}, bad, 0);
      check({tag, " done cycle"}, done_n, 41 + 2 * el);
      check({tag, " flash cmd"}, 32'(cap[31:24]), 32'h6B);
      check({tag, " flash addr"}, 32'(cap[23:0]), 32'(ea));
      step();
      check({tag, " release"}, {gnt, spi_cs_n, spi_clk_en}, {2'b00, 1'b1, 1'b0});
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      mem[8'h20] = 8'hA5;
      mem[8'h21] = 8'h3C;
      vt[0] = '{2'b01, 24'h000410, 7'd16, 24'h000000, 7'd0, 2'b01, 24'h000410, 16};
      vt[1] = '{2'b10, 24'h000000, 7'd0, 24'h123420, 7'd2, 2'b10, 24'h123420, 2};
      vt[2] = '{2'b11, 24'h00AB00, 7'd3, 24'h555555, 7'd4, 2'b01, 24'h00AB00, 3};
      vt[3] = '{2'b10, 24'h000000, 7'd0, 24'hFFFFFE, 7'd4, 2'b10, 24'hFFFFFE, 4};
      vt[4] = '{2'b01, 24'h000021, 7'd1, 24'h000000, 7'd0, 2'b01, 24'h000021, 1};
      repeat (3) step();
      check("reset outs", {gnt, rd_valid, done, busy, spi_cs_n, spi_clk_en, spi_io_out, spi_io_oe, rd_data},
            {2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00});
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_idle();
         req0_addr = vt[i].a0;
         req0_len  = vt[i].l0;
         req1_addr = vt[i].a1;
         req1_len  = vt[i].l1;
         req       = vt[i].req;
         step();
         burst($sformatf("vec%0d", i), vt[i].eg, vt[i].ea, vt[i].el);
         req = 2'b00;
      end
      wait_idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      req0_addr = 24'h000030;
      req0_len  = 7'd1;
      req1_addr = 24'h000040;
      req1_len  = 7'd1;
      req       = 2'b11;
      step();
      burst("tie1", 2'b01, 24'h000030, 1);
      wait_grant(gap_n);
      check("tie2 gap", gap_n, 2);
`ifdef QSPI_RR_ARB_EN
      burst("tie2", 2'b10, 24'h000040, 1);
`else
      burst("tie2", 2'b01, 24'h000030, 1);
`endif
      req = 2'b10;
      wait_grant(gap_n);
      check("req1 gap", gap_n, 2);
      burst("req1 after gap", 2'b10, 24'h000040, 1);
      req = 2'b00;
      wait_idle();
      req0_addr = 24'h000010;
      req0_len  = 7'd16;
      req       = 2'b01;
      step();
      seen = 0;
      for (int k = 0; k < 60 && seen < 4; k++) begin
         step();
         if (rd_valid != 2'b00) seen++;
      end
      check("bytes before reset", seen, 4);
      step();
      reset = 1'b1;
      step();
      check("mid-burst reset", {gnt, rd_valid, done, busy, spi_cs_n, spi_clk_en, spi_io_oe, spi_io_out},
            {2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
      reset = 1'b0;
      step();
      burst("restart", 2'b01, 24'h000010, 16);
      req = 2'b00;
      wait_idle();
      req1_len = 7'd0;
      req      = 2'b10;
      step();
      check("len0 grant", {gnt, done, busy, spi_cs_n, spi_clk_en}, {2'b10, 2'b00, 1'b1, 1'b1, 1'b0});
      step();
      check("len0 done", {gnt, done, spi_cs_n, spi_clk_en}, {2'b00, 2'b10, 1'b1, 1'b0});
      req = 2'b00;
      step();
      step();
      check("len0 idle", {gnt, done, busy, spi_cs_n}, {2'b00, 2'b00, 1'b0, 1'b1});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
